pipe_stage_buf: RTL and testbench

- Parametrised elastic pipeline-stage register, the successor to the fixed-field decode/ALU stage buffers.
- Carries one control bundle and one data bundle between any two pipeline stages, using a valid/ready handshake in both directions.
- Supports stall (back-pressure), flush (bubble insertion) and an optional skid entry that breaks the combinational ready path.
- Instantiated between the fetch/decode, decode/ALU, ALU/memory and memory/writeback stages.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_entry.sv | 59 +++++
 rtl/pipe_stage_buf.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the elastic pipeline-stage buffers.
//
// Contents:
//   ST_EMPTY / ST_ONE / ST_TWO : occupancy-state encoding. The encoding
//                                equals the number of held entries, so the
//                                state register doubles as o_count.
//   CTRL_W_DEFAULT / DATA_W_DEFAULT : default bundle widths.
//   <STAGE>_CTRL_W / <STAGE>_DATA_W  : bundle widths for each stage boundary.
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int CTRL_W_DEFAULT = 4;
    localparam int DATA_W_DEFAULT = 73;

    // Stage-boundary interfaces. All four currently share the default
    // layout. They are kept separate so one boundary can widen without
    // touching the others.
    localparam int IF_ID_CTRL_W  = CTRL_W_DEFAULT;
    localparam int IF_ID_DATA_W  = DATA_W_DEFAULT;
    localparam int ID_EX_CTRL_W  = CTRL_W_DEFAULT;
    localparam int ID_EX_DATA_W  = DATA_W_DEFAULT;
    localparam int EX_MEM_CTRL_W = CTRL_W_DEFAULT;
    localparam int EX_MEM_DATA_W = DATA_W_DEFAULT;
    localparam int MEM_WB_CTRL_W = CTRL_W_DEFAULT;
    localparam int MEM_WB_DATA_W = DATA_W_DEFAULT;

endpackage

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
//
// One register slot of a pipeline-stage buffer: a valid bit, a control
// bundle and a data bundle.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset; clears valid, ctrl and data
//   load    in   capture d_ctrl/d_data and mark the slot valid
//   clear   in   drop the entry: valid and ctrl go to zero, data is kept
//   d_ctrl  in   [CTRL_W] control bundle to load
//   d_data  in   [DATA_W] data bundle to load
//   valid   out  slot holds an entry
//   q_ctrl  out  [CTRL_W] held control bundle, zero whenever valid = 0
//   q_data  out  [DATA_W] held data bundle
//
// With neither load nor clear asserted, the slot holds its contents.
// clear wins over load, so a flush can never be overridden by a
// simultaneous capture.
// ---------------------------------------------------------------------------
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // NOTE: state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            q_ctrl <= '0;
            // NOTE: the data bundle is reset here because o_data must read
            // zero after reset. A clear leaves it alone, since data is a
            // don't-care on a bubble and skipping it saves enable fan-out.
            q_data <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
            q_ctrl <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Elastic pipeline-stage register with a valid/ready handshake on both
// sides. It sits between fetch/decode, decode/ALU, ALU/memory and
// memory/writeback.
//
// Parameters:
//   CTRL_W  width of the control bundle (zeroed on every bubble)
//   DATA_W  width of the data bundle (left as is on a bubble)
//   SKID    1: main + skid entry, registered o_ready = !skid_valid
//           0: main entry only, o_ready combinational from i_ready
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset. Highest priority.
//   flush    in   drop all held entries and any push this cycle
//   i_valid  in   upstream presents an entry
//   o_ready  out  an entry is accepted this cycle (0 while rst is high)
//   i_ctrl   in   [CTRL_W] upstream control bundle
//   i_data   in   [DATA_W] upstream data bundle
//   o_valid  out  head entry is valid
//   i_ready  in   downstream takes the head entry this cycle
//   o_ctrl   out  [CTRL_W] head control bundle, zero when o_valid = 0
//   o_data   out  [DATA_W] head data bundle
//   o_count  out  [2] number of held entries (0..2)
//
// Push = i_valid & o_ready and pop = o_valid & i_ready. The head is always
// the main entry. The skid entry only refills main, so arrival order is
// preserved.
// ---------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              push;
    logic              pop;

    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    generate
        if (SKID != 0) begin : g_ready_reg
            // skid_valid is a flop, so o_ready has no combinational path
            // from i_ready. The rst term only masks the reset cycle itself.
            assign o_ready = !rst & !skid_valid;
        end else begin : g_ready_comb
            // With a single entry, the head can be replaced in the same
            // cycle it leaves, so ready has to look at i_ready.
            assign o_ready = !rst & (!main_valid | i_ready);
        end
    endgenerate

    assign push = i_valid & o_ready;
    assign pop  = main_valid & i_ready;

    // ------------------------------------------------------------------
    // Occupancy state machine
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so
    // no path through the case leaves one unassigned (no latches).
    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if (flush) begin
            // Any push this cycle is dropped. A pop this cycle still left
            // downstream, so there is nothing further to undo.
            next_state = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        main_load  = 1'b1;
                        next_state = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        // Only reachable with SKID = 1. With SKID = 0,
                        // o_ready in ONE already implies a pop.
                        skid_load  = 1'b1;
                        next_state = ST_TWO;
                    end else if (pop) begin
                        main_clear = 1'b1;
                        next_state = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // No push can arrive here, because o_ready = 0.
                    if (pop) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        next_state     = ST_ONE;
                    end
                end
                default: begin
                    next_state = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    assign main_d_ctrl = main_from_skid ? skid_ctrl : i_ctrl;
    assign main_d_data = main_from_skid ? skid_data : i_data;

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clear),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .valid  (main_valid),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load   (skid_load),
                .clear  (skid_clear),
                .d_ctrl (i_ctrl),
                .d_data (i_data),
                .valid  (skid_valid),
                .q_ctrl (skid_ctrl),
                .q_data (skid_data)
            );
        end else begin : g_no_skid
            logic unused_skid_ctl;
            assign unused_skid_ctl = skid_load | skid_clear;
            assign skid_valid      = 1'b0;
            assign skid_ctrl       = '0;
            assign skid_data       = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The state encoding equals the entry count.
    assign o_valid = main_valid;
    assign o_ctrl  = main_ctrl;
    assign o_data  = main_data;
    assign o_count = state;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Testbench for pipe_stage_buf. The main instance (SKID = 1) is checked
// every cycle against a queue of expected entries. Directed phases add
// hand-computed checks. A second instance (SKID = 0) is checked with
// directed vectors for the combinational ready path and head replacement.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int CW = CTRL_W_DEFAULT;
    localparam int DW = DATA_W_DEFAULT;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;

    // SKID = 1 instance
    logic          flush, i_valid, i_ready, o_ready, o_valid;
    logic [CW-1:0] i_ctrl, o_ctrl;
    logic [DW-1:0] i_data, o_data;
    logic [1:0]    o_count;

    // SKID = 0 instance
    logic          s0_flush, s0_i_valid, s0_i_ready, s0_o_ready, s0_o_valid;
    logic [CW-1:0] s0_i_ctrl, s0_o_ctrl;
    logic [DW-1:0] s0_i_data, s0_o_data;
    logic [1:0]    s0_o_count;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_ctrl  (i_ctrl),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_ctrl  (o_ctrl),
        .o_data  (o_data),
        .o_count (o_count)
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .flush   (s0_flush),
        .i_valid (s0_i_valid),
        .o_ready (s0_o_ready),
        .i_ctrl  (s0_i_ctrl),
        .i_data  (s0_i_data),
        .o_valid (s0_o_valid),
        .i_ready (s0_i_ready),
        .o_ctrl  (s0_o_ctrl),
        .o_data  (s0_o_data),
        .o_count (s0_o_count)
    );

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the SKID = 1 instance. It samples on the
    // falling edge, compares the DUT against the expected queue, then
    // applies this cycle's handshake to the queue.
    always @(negedge clk) begin
        logic m_ready;
        m_ready = !rst && (exp_q.size() < 2);
        check("sb_o_ready", 128'(o_ready), 128'(m_ready));
        check("sb_o_count", 128'(o_count), 128'(exp_q.size()));
        check("sb_o_valid", 128'(o_valid), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("sb_o_ctrl", 128'(o_ctrl), 128'(exp_q[0].ctrl));
            check("sb_o_data", 128'(o_data), 128'(exp_q[0].data));
        end else begin
            check("sb_bubble_ctrl", 128'(o_ctrl), 128'(0));
        end
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0 && i_ready) void'(exp_q.pop_front());
            if (i_valid && m_ready) exp_q.push_back('{ctrl: i_ctrl, data: i_data});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] rnd;
        rst = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_ctrl = '0; i_data = '0;
        s0_flush = 1'b0; s0_i_valid = 1'b0; s0_i_ready = 1'b0;
        s0_i_ctrl = '0; s0_i_data = '0;

        // ---- reset state ----
        step(); step();
        #1;
        check("rst_o_valid", 128'(o_valid), 128'(0));
        check("rst_o_ctrl",  128'(o_ctrl),  128'(0));
        check("rst_o_data",  128'(o_data),  128'(0));
        check("rst_o_count", 128'(o_count), 128'(0));
        check("rst_o_ready", 128'(o_ready), 128'(0));
        check("rst_s0_o_ready", 128'(s0_o_ready), 128'(0));
        rst = 1'b0;
        #1;
        check("post_rst_o_ready", 128'(o_ready), 128'(1));

        // ---- reset mid-stream: fill to TWO with A then 5 ----
        i_ready = 1'b0; i_valid = 1'b1; i_ctrl = 4'hA; i_data = 73'h0A;
        step();
        i_ctrl = 4'h5; i_data = 73'h05;
        step();
        i_valid = 1'b0;
        #1;
        check("two_o_count", 128'(o_count), 128'(2));
        check("two_o_ready", 128'(o_ready), 128'(0));
        check("two_o_ctrl",  128'(o_ctrl),  128'(4'hA));
        rst = 1'b1;
        #1;
        check("midrst_o_ready", 128'(o_ready), 128'(0));
        step();
        check("midrst_o_valid", 128'(o_valid), 128'(0));
        check("midrst_o_ctrl",  128'(o_ctrl),  128'(0));
        check("midrst_o_count", 128'(o_count), 128'(0));
        rst = 1'b0;
        #1;
        check("midrst_after_o_ready", 128'(o_ready), 128'(1));

        // ---- streaming 1..4 ----
        i_ready = 1'b1; i_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            i_ctrl = CW'(k); i_data = DW'(k * 16);
            step();
            check("stream_o_ctrl",  128'(o_ctrl),  128'(k));
            check("stream_o_data",  128'(o_data),  128'(k * 16));
            check("stream_o_count", 128'(o_count), 128'(1));
            check("stream_o_ready", 128'(o_ready), 128'(1));
        end
        i_valid = 1'b0;
        step();
        check("stream_drain_o_valid", 128'(o_valid), 128'(0));
        check("stream_drain_o_ctrl",  128'(o_ctrl),  128'(0));

        // ---- stall and skid ----
        i_ready = 1'b0; i_valid = 1'b1; i_ctrl = 4'h1; i_data = 73'h1111;
        step();
        i_ctrl = 4'h2; i_data = 73'h2222;
        step();
        i_valid = 1'b0;
        #1;
        check("skid_o_count", 128'(o_count), 128'(2));
        check("skid_o_ready", 128'(o_ready), 128'(0));
        check("skid_o_data",  128'(o_data),  128'(16'h1111));
        step();
        check("stall_hold_o_data", 128'(o_data), 128'(16'h1111));
        check("stall_hold_o_ctrl", 128'(o_ctrl), 128'(4'h1));
        i_ready = 1'b1;
        step();
        check("skid_pop1_o_data",  128'(o_data),  128'(16'h2222));
        check("skid_pop1_o_ready", 128'(o_ready), 128'(1));
        check("skid_pop1_o_count", 128'(o_count), 128'(1));
        step();
        check("skid_pop2_o_count", 128'(o_count), 128'(0));
        check("skid_pop2_o_ctrl",  128'(o_ctrl),  128'(0));

        // ---- flush with simultaneous push ----
        i_ready = 1'b0; i_valid = 1'b1; i_ctrl = 4'h3; i_data = 73'h33;
        step();
        flush = 1'b1; i_ctrl = 4'hF; i_data = 73'hFF;
        step();
        check("flush_o_valid", 128'(o_valid), 128'(0));
        check("flush_o_ctrl",  128'(o_ctrl),  128'(0));
        check("flush_o_count", 128'(o_count), 128'(0));
        flush = 1'b0; i_valid = 1'b0;
        step();
        check("flush_after_o_valid", 128'(o_valid), 128'(0));
        check("flush_after_o_ctrl",  128'(o_ctrl),  128'(0));

        // ---- SKID = 0: combinational ready and head replacement ----
        s0_i_ready = 1'b0; s0_i_valid = 1'b1; s0_i_ctrl = 4'h7; s0_i_data = 73'h77;
        step();
        s0_i_valid = 1'b0;
        #1;
        check("s0_o_valid", 128'(s0_o_valid), 128'(1));
        check("s0_o_ctrl",  128'(s0_o_ctrl),  128'(4'h7));
        check("s0_ready_stalled", 128'(s0_o_ready), 128'(0));
        s0_i_ready = 1'b1;
        #1;
        check("s0_ready_comb", 128'(s0_o_ready), 128'(1));
        s0_i_valid = 1'b1; s0_i_ctrl = 4'h9; s0_i_data = 73'h99;
        step();
        check("s0_replace_o_valid", 128'(s0_o_valid), 128'(1));
        check("s0_replace_o_ctrl",  128'(s0_o_ctrl),  128'(4'h9));
        check("s0_replace_o_data",  128'(s0_o_data),  128'(8'h99));
        check("s0_replace_o_count", 128'(s0_o_count), 128'(1));
        s0_i_valid = 1'b0; s0_i_ready = 1'b0;
        step();
        check("s0_stall_o_ctrl",  128'(s0_o_ctrl),  128'(4'h9));
        check("s0_stall_o_count", 128'(s0_o_count), 128'(1));
        s0_i_ready = 1'b1;
        step();
        check("s0_empty_o_valid", 128'(s0_o_valid), 128'(0));
        check("s0_empty_o_ctrl",  128'(s0_o_ctrl),  128'(0));
        check("s0_empty_o_count", 128'(s0_o_count), 128'(0));

        // ---- random back-pressure with rare flush ----
        for (int c = 0; c < 1000; c++) begin
            rnd     = {$urandom, $urandom, $urandom};
            i_valid = ($urandom_range(0, 99) < 60);
            i_ready = ($urandom_range(0, 99) < 55);
            flush   = ($urandom_range(0, 39) == 0);
            i_ctrl  = rnd[95:92];
            i_data  = rnd[72:0];
            step();
        end
        i_valid = 1'b0; i_ready = 1'b1; flush = 1'b0;
        step(); step(); step();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
